// File: rtl/lzy_counter_pkg.sv
// Types shared by the lzy 74HC-style counter family (up and down stages).
package lzy_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_RELOAD  = 2'b01,
    MODE_ONESHOT = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_EXPIRED = 2'b10
  } state_e;

  // The unused encoding 2'b11 behaves exactly like wrap mode.
  function automatic mode_e norm_mode(input logic [1:0] mode_raw);
    mode_e m;
    case (mode_raw)
      2'b01:   m = MODE_RELOAD;
      2'b10:   m = MODE_ONESHOT;
      default: m = MODE_WRAP;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lzy_zero_detect.sv
// WIDTH-wide all-zero detector, used for the borrow output and the zero-step logic.
module lzy_zero_detect #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] value_i,
  output logic             zero_o
);

  assign zero_o = ~|value_i;

endmodule

// File: rtl/lzy_74hc_down_counter.sv
// Presettable synchronous down-counter stage with borrow, reload register and one-shot mode.
module lzy_74hc_down_counter
  import lzy_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             MR,
  input  logic             CEP,
  input  logic             CET,
  input  logic             PE,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             B,
  output logic             DONE
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  state_e           state_q, state_d;
  mode_e            mode;
  logic             q_zero;
  logic             run_ok;
  logic             en;

  lzy_zero_detect #(.WIDTH(WIDTH)) u_zero (
    .value_i (q_q),
    .zero_o  (q_zero)
  );

  assign mode   = norm_mode(MODE);
  // A one-shot only counts once it has been armed by a load and has not yet expired.
  assign run_ok = !((mode == MODE_ONESHOT) && (state_q != ST_RUN));
  assign en     = CEP & CET & PE & run_ok;

  always_comb begin
    q_d     = q_q;
    r_d     = r_q;
    state_d = state_q;
    if (!PE) begin
      q_d     = D;
      r_d     = D;
      state_d = ST_RUN;
    end else if (en) begin
      if (state_q == ST_IDLE) state_d = ST_RUN;
      if (!q_zero) begin
        q_d = q_q - ONE;
      end else begin
        case (mode)
          MODE_RELOAD:  q_d = r_q;
          MODE_ONESHOT: state_d = ST_EXPIRED;
          default:      q_d = '1;
        endcase
      end
    end
  end

  always_ff @(posedge Clk or negedge MR) begin
    if (!MR) begin
      q_q     <= '0;
      r_q     <= '0;
      state_q <= ST_IDLE;
    end else begin
      q_q     <= q_d;
      r_q     <= r_d;
      state_q <= state_d;
    end
  end

  assign Q    = q_q;
  // Same gating as a 74HC161 carry: CET only, so a cascade ripples in a single clock.
  assign B    = CET & q_zero & !((mode == MODE_ONESHOT) && (state_q != ST_RUN));
  assign DONE = (state_q == ST_EXPIRED);

endmodule
